// File: rtl/seg_disp_sched_pkg.sv
// -----------------------------------------------------------------------------
// seg_disp_pkg
//   Shared types and constants for the seven-segment display scheduler and its
//   round-robin arbiter.
//   - SEG_DATA_W : width of one display word (drives seven_seg.data).
//   - MAX_REQ    : largest supported requester count.
//   - IDX_W      : width of a requester index (sized for MAX_REQ).
//   - sched_state_t : scheduler FSM states.
// -----------------------------------------------------------------------------
package seg_disp_pkg;

    localparam int SEG_DATA_W = 32;
    localparam int MAX_REQ    = 8;
    localparam int IDX_W      = $clog2(MAX_REQ);

    typedef enum logic {
        IDLE = 1'b0,   // no owner, display holds the last value
        SHOW = 1'b1    // owner displayed, dwell counter running
    } sched_state_t;

endpackage

// File: rtl/seg_disp_sched_if.sv
// -----------------------------------------------------------------------------
// seg_disp_sched_if
//   Bundle between the application requesters and the display scheduler.
//   Ports (per signal, direction seen from the scheduler):
//   - req        in   N_REQ        level request per requester
//   - req_data   in   32*N_REQ     requester i value at [32*i+31:32*i]
//   - ack        out  N_REQ        one-cycle pulse when a request is granted
//   - done       out  N_REQ        one-cycle pulse when the owner's dwell ends
//   - disp_data  out  32           word driven into seven_seg.data
//   - disp_valid out  1            low until the first grant
//   - owner      out  IDX_W        index of the current / last owner
//   Modports: master = requester side, slave = scheduler side.
// -----------------------------------------------------------------------------
interface seg_disp_sched_if #(
    parameter int N_REQ = 4
);
    import seg_disp_pkg::*;

    logic [N_REQ-1:0]            req;
    logic [SEG_DATA_W*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]            ack;
    logic [N_REQ-1:0]            done;
    logic [SEG_DATA_W-1:0]       disp_data;
    logic                        disp_valid;
    logic [IDX_W-1:0]            owner;

    modport master (
        output req,
        output req_data,
        input  ack,
        input  done,
        input  disp_data,
        input  disp_valid,
        input  owner
    );

    modport slave (
        input  req,
        input  req_data,
        output ack,
        output done,
        output disp_data,
        output disp_valid,
        output owner
    );

endinterface

// File: rtl/seg_disp_sched_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
//   Combinational round-robin pick for an N_REQ-wide request vector. The search
//   starts at last_grant+1 and wraps, so the most recent winner has the lowest
//   priority next time. Reusable by any shared-resource controller.
//   Ports:
//   - req        in   N_REQ   request vector
//   - last_grant in   IDX_W   index of the previous winner
//   - grant_idx  out  IDX_W   selected index (0 when grant_any is low)
//   - grant_any  out  1       at least one request is set
// -----------------------------------------------------------------------------
module rr_arbiter
    import seg_disp_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last_grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_any
);

    always_comb begin
        int               cand;
        logic [N_REQ-1:0] shifted;
        cand      = 0;
        shifted   = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        // last_grant < N_REQ and k <= N_REQ, so one subtraction is enough to wrap.
        for (int k = 1; k <= N_REQ; k++) begin
            cand = int'(last_grant) + k;
            if (cand >= N_REQ) begin
                cand = cand - N_REQ;
            end
            shifted = req >> cand;
            if (!grant_any && shifted[0]) begin
                grant_any = 1'b1;
                grant_idx = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/seg_disp_sched.sv
// -----------------------------------------------------------------------------
// seg_disp_sched
//   Shares the single 32-bit hex display between N_REQ requesters. A granted
//   value is held for exactly DWELL cycles, then the display rotates to the
//   next pending requester (round-robin). No preemption; req_data is sampled
//   only on the grant edge. All outputs are registered.
//   Ports:
//   - clk     in  1   system clock
//   - resetn  in  1   asynchronous active-low reset
//   - bus     slave modport of seg_disp_sched_if (req/req_data in;
//             ack/done/disp_data/disp_valid/owner out)
// -----------------------------------------------------------------------------
module seg_disp_sched
    import seg_disp_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int DWELL = 50_000_000
) (
    input  logic            clk,
    input  logic            resetn,
    seg_disp_sched_if.slave bus
);

    localparam int               CNT_W    = $clog2(DWELL);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DWELL - 1);
    localparam logic [N_REQ-1:0] ONE_HOT0 = N_REQ'(1);

    sched_state_t          state, state_nxt;
    logic [CNT_W-1:0]      dwell_cnt, dwell_cnt_nxt;
    logic [IDX_W-1:0]      last_grant, last_grant_nxt;
    logic [IDX_W-1:0]      owner_q, owner_nxt;
    logic [SEG_DATA_W-1:0] disp_data_q, disp_data_nxt;
    logic                  disp_valid_q, disp_valid_nxt;
    logic [N_REQ-1:0]      ack_q, ack_nxt;
    logic [N_REQ-1:0]      done_q, done_nxt;

    logic [IDX_W-1:0]      grant_idx;
    logic                  grant_any;
    logic [SEG_DATA_W-1:0] sel_data;
    logic                  do_grant;

    rr_arbiter #(
        .N_REQ      (N_REQ)
    ) u_arb (
        .req        (bus.req),
        .last_grant (last_grant),
        .grant_idx  (grant_idx),
        .grant_any  (grant_any)
    );

    assign sel_data = SEG_DATA_W'(bus.req_data >> (SEG_DATA_W * int'(grant_idx)));

    always_comb begin
        state_nxt      = state;
        dwell_cnt_nxt  = dwell_cnt;
        last_grant_nxt = last_grant;
        owner_nxt      = owner_q;
        disp_data_nxt  = disp_data_q;
        disp_valid_nxt = disp_valid_q;
        ack_nxt        = '0;
        done_nxt       = '0;
        do_grant       = 1'b0;

        case (state)
            IDLE: begin
                if (grant_any) begin
                    do_grant = 1'b1;
                end
            end
            SHOW: begin
                if (dwell_cnt == '0) begin
                    // Dwell over: release the owner and, if anyone is waiting,
                    // hand over on this same edge so there is no gap cycle.
                    done_nxt = ONE_HOT0 << owner_q;
                    if (grant_any) begin
                        do_grant = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    dwell_cnt_nxt = dwell_cnt - 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (do_grant) begin
            state_nxt      = SHOW;
            dwell_cnt_nxt  = CNT_LOAD;
            last_grant_nxt = grant_idx;
            owner_nxt      = grant_idx;
            disp_data_nxt  = sel_data;
            disp_valid_nxt = 1'b1;
            ack_nxt        = ONE_HOT0 << grant_idx;
        end
    end

    // last_grant starts at N_REQ-1 so requester 0 wins the first arbitration.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= IDLE;
            dwell_cnt    <= '0;
            last_grant   <= IDX_W'(N_REQ - 1);
            owner_q      <= '0;
            disp_data_q  <= '0;
            disp_valid_q <= 1'b0;
            ack_q        <= '0;
            done_q       <= '0;
        end else begin
            state        <= state_nxt;
            dwell_cnt    <= dwell_cnt_nxt;
            last_grant   <= last_grant_nxt;
            owner_q      <= owner_nxt;
            disp_data_q  <= disp_data_nxt;
            disp_valid_q <= disp_valid_nxt;
            ack_q        <= ack_nxt;
            done_q       <= done_nxt;
        end
    end

    assign bus.ack        = ack_q;
    assign bus.done       = done_q;
    assign bus.disp_data  = disp_data_q;
    assign bus.disp_valid = disp_valid_q;
    assign bus.owner      = owner_q;

endmodule

// File: tb/tb_seg_disp_sched.sv
// -----------------------------------------------------------------------------
// tb_seg_disp_sched
//   Scoreboard bench for seg_disp_sched (N_REQ=4, DWELL=4). The stimulus side
//   advances a behavioural model one clock at a time and queues every expected
//   ack/done event; an independent monitor compares DUT events as they appear.
// -----------------------------------------------------------------------------
module tb_seg_disp_sched;
    import seg_disp_pkg::*;

    localparam int N  = 4;
    localparam int DW = 4;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    seg_disp_sched_if #(.N_REQ(N)) bus();

    seg_disp_sched #(
        .N_REQ (N),
        .DWELL (DW)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    typedef struct {
        int          cyc;
        logic [N-1:0] ack;
        logic [N-1:0] done;
        logic [2:0]  owner;
        logic [31:0] data;
        logic        valid;
    } exp_t;

    exp_t        expq[$];
    exp_t        mon_e;
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    logic [31:0] dval [N];

    // Behavioural model: cycles left in the current grant (0 = idle).
    int          m_rem;
    int          m_cur;
    int          m_last;
    logic [31:0] m_shown;
    logic        m_valid;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // First requester found searching upward from last+1, wrapping.
    function automatic int pick(input int last, input logic [N-1:0] r);
        logic [N-1:0] s;
        for (int off = 1; off <= N; off++) begin
            s = r >> ((last + off) % N);
            if (s[0]) return (last + off) % N;
        end
        return -1;
    endfunction

    function automatic void model_reset();
        m_rem   = 0;
        m_cur   = 0;
        m_last  = N - 1;
        m_shown = 32'h0;
        m_valid = 1'b0;
    endfunction

    // Drive one cycle of stimulus and predict what the coming edge produces.
    task automatic step(input logic [N-1:0] r);
        exp_t         e;
        logic [N-1:0] a;
        logic [N-1:0] d;
        int           g;
        @(negedge clk);
        bus.req      = r;
        bus.req_data = {dval[3], dval[2], dval[1], dval[0]};
        a = '0;
        d = '0;
        if (m_rem > 1) begin
            m_rem--;
        end else begin
            if (m_rem == 1) d = N'(1) << m_cur;
            g = pick(m_last, r);
            if (g >= 0) begin
                a       = N'(1) << g;
                m_cur   = g;
                m_last  = g;
                m_rem   = DW;
                m_shown = dval[g];
                m_valid = 1'b1;
            end else begin
                m_rem = 0;
            end
        end
        if ((a | d) != '0) begin
            e.cyc   = cyc + 1;
            e.ack   = a;
            e.done  = d;
            e.owner = 3'(m_cur);
            e.data  = m_shown;
            e.valid = m_valid;
            expq.push_back(e);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_disp_data"},  bus.disp_data, 32'h0);
        check({tag, "_disp_valid"}, 32'(bus.disp_valid), 32'h0);
        check({tag, "_owner"},      32'(bus.owner), 32'h0);
        check({tag, "_ack"},        32'(bus.ack), 32'h0);
        check({tag, "_done"},       32'(bus.done), 32'h0);
    endtask

    // Reset asserted mid-cycle, after the most recent edge has been consumed.
    task automatic do_reset();
        @(posedge clk);
        #2;
        resetn  = 1'b0;
        bus.req = '0;
        #1;
        check_reset_outputs("midshow_rst");
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
    endtask

    // Monitor: compare whenever the DUT presents an ack/done event, and flag
    // any expected event whose cycle passes silently.
    always @(posedge clk) begin
        #1;
        if (resetn === 1'b1) begin
            if (bus.ack != '0 || bus.done != '0) begin
                if (expq.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_event: ack=%b done=%b, none expected (cycle %0d)",
                             bus.ack, bus.done, cyc);
                end else begin
                    mon_e = expq.pop_front();
                    check("event_cycle", 32'(cyc), 32'(mon_e.cyc));
                    check("ack",         32'(bus.ack), 32'(mon_e.ack));
                    check("done",        32'(bus.done), 32'(mon_e.done));
                    check("owner",       32'(bus.owner), 32'(mon_e.owner));
                    check("disp_data",   bus.disp_data, mon_e.data);
                    check("disp_valid",  32'(bus.disp_valid), 32'(mon_e.valid));
                end
            end else if (expq.size() > 0 && expq[0].cyc <= cyc) begin
                mon_e = expq.pop_front();
                n_tests++;
                n_fail++;
                $display("FAIL missing_event: got ack=%b done=%b, expected ack=%b done=%b (cycle %0d)",
                         bus.ack, bus.done, mon_e.ack, mon_e.done, cyc);
            end
        end
    end

    logic rq [N];
    logic [N-1:0] rv;

    initial begin
        resetn       = 1'b0;
        bus.req      = '0;
        bus.req_data = '0;
        for (int i = 0; i < N; i++) dval[i] = 32'h0;
        model_reset();
        repeat (3) @(posedge clk);
        #2;
        check_reset_outputs("reset");
        @(negedge clk);
        resetn = 1'b1;

        // Reset / first grant
        dval[0] = 32'h1234_5678;
        dval[1] = 32'hA1A1_0001;
        dval[2] = 32'hA2A2_0002;
        dval[3] = 32'hA3A3_0003;
        step(4'b0001);
        @(posedge clk);
        #2;
        check("first_ack",        32'(bus.ack), 32'h1);
        check("first_disp_data",  bus.disp_data, 32'h1234_5678);
        check("first_disp_valid", 32'(bus.disp_valid), 32'h1);
        check("first_owner",      32'(bus.owner), 32'h0);

        // Full contention: owners 0,1,2,3,0 then 1 again
        repeat (20) step(4'b1111);
        // Rotation skip: only requester 0 while owner 1 shows
        repeat (4) step(4'b0001);
        repeat (4) step(4'b0000);

        // Idle hold
        dval[0] = 32'hDEAD_BEEF;
        step(4'b0001);
        repeat (8) step(4'b0000);
        @(posedge clk);
        #2;
        check("idle_hold_data",  bus.disp_data, 32'hDEAD_BEEF);
        check("idle_hold_valid", 32'(bus.disp_valid), 32'h1);

        // Withdrawal and data sampling
        dval[0] = 32'hCAFE_0001;
        step(4'b0001);
        step(4'b0000);
        dval[0] = 32'h0BAD_F00D;
        dval[2] = 32'h2222_2222;
        step(4'b0100);
        step(4'b0000);
        @(posedge clk);
        #2;
        check("sampled_data_held", bus.disp_data, 32'hCAFE_0001);
        step(4'b0000);
        repeat (3) step(4'b0000);

        // Reset mid-SHOW (counter at 2), then lowest requesting index wins
        dval[3] = 32'h3333_3333;
        step(4'b1000);
        step(4'b0000);
        do_reset();
        dval[1] = 32'h1111_1111;
        step(4'b1010);
        repeat (5) step(4'b0000);

        // Randomized traffic; data only changes while its request is low
        for (int b = 0; b < N; b++) rq[b] = 1'b0;
        for (int i = 0; i < 400; i++) begin
            rv = '0;
            for (int b = 0; b < N; b++) begin
                if (rq[b]) begin
                    if ($urandom_range(3) == 0) rq[b] = 1'b0;
                end else if ($urandom_range(2) == 0) begin
                    dval[b] = $urandom;
                    rq[b]   = 1'b1;
                end
                rv = rv | (N'(rq[b]) << b);
            end
            step(rv);
        end

        repeat (10) step(4'b0000);
        @(posedge clk);
        #2;
        check("queue_drained", 32'(expq.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/seg_disp_sched.md
# seg_disp_sched

Round-robin scheduler that shares the single 32-bit hex display datapath (`seven_seg.data`) between several requesters.
- Each requester raises a request carrying a 32-bit value.
- The scheduler grants the display to one requester at a time and holds that value for a fixed dwell time.
- It then rotates to the next pending requester.
- It sits between application sources (counters, status, debug words) and `seven_seg`, and drives its `data` input directly.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters, 2..8.
- `DWELL`, 50_000_000: display cycles per grant, ≥ 2.

Ports:
- `clk`  in  1  system clock.
- `resetn`  in  1  asynchronous active-low reset.
- `req`  in  N_REQ  level request per requester.
- `req_data`  in  32*N_REQ  requester i value at bits [32*i+31:32*i]; stable while `req[i]`=1.
- `ack`  out  N_REQ  one-cycle pulse: request latched, display owned.
- `done`  out  N_REQ  one-cycle pulse: owner's dwell expired.
- `disp_data`  out  32  to `seven_seg.data`.
- `disp_valid`  out  1  0 until first grant; 1 afterwards.
- `owner`  out  3  index of current/last owner.

## Operation
- FSM states:
  - IDLE: no owner; display holds last value.
  - SHOW: owner displayed; dwell counter running.
- **Grant (IDLE, any `req`=1):**
  - Round-robin pick: first set bit searching upward from `last_grant+1`, wrapping.
  - On the grant edge: `disp_data`←selected `req_data`; `owner`←index; `ack[index]`=1 for one cycle; `dwell_cnt`←DWELL-1; `disp_valid`←1; `last_grant`←index; go SHOW.
- **SHOW:**
  - `dwell_cnt` decrements each cycle.
  - At `dwell_cnt`==0 on an edge: `done[owner]`=1 for one cycle.
  - If any `req` is set in that cycle, grant the next requester on the same edge; `ack` and `done` may both pulse, for different or equal indices.
  - Otherwise go IDLE.
- **No preemption.** `req` changes during SHOW affect only the next arbitration.
- **Requester's own bit:**
  - A requester's `req` bit is ignored for re-grant only through rotation order.
  - A requester still requesting after `ack` is treated as a new request and is re-granted when rotation reaches it.
  - A sole requester holding `req` continuously is re-granted every DWELL cycles with fresh data.
- **Withdrawal:** `req` dropped before `ack` is a withdrawal; no ack, no error.
- **Data sampling:** `req_data` is sampled only on the grant edge. Later changes are not shown until the next grant.
- **Reset (async, resetn=0):**
  - Outputs: `disp_data`=0, `disp_valid`=0, `ack`=0, `done`=0, `owner`=0.
  - Internal: state IDLE, `dwell_cnt`=0, `last_grant`=N_REQ-1, so requester 0 has first priority.
- **Reset mid-SHOW:** abandons the grant; no `done` issued.

## Timing
- **Latency:** `req[i]` high before edge k in IDLE gives `ack[i]` and new `disp_data` visible after edge k (1 cycle).
- **Dwell length:**
  - A granted value is displayed for exactly DWELL cycles, from grant edge to the next grant or IDLE edge.
  - Back-to-back grants leave zero gap.
- **Dwell counter:** width $clog2(DWELL); no wrap; reloaded only at grant.
- **Registered outputs:** all outputs are registered; no combinational path from `req` to any output.
- **Fairness:** with all N_REQ requesting continuously, each is granted once per N_REQ×DWELL cycles in ascending cyclic order.

## Structure
- **Package `seg_disp_pkg`:**
  - state enum {IDLE, SHOW};
  - `SEG_DATA_W`=32;
  - `MAX_REQ`=8.
- **Sub-module `rr_arbiter`:** combinational, N_REQ-wide.
  - Inputs: `req`, `last_grant`.
  - Outputs: `grant_idx`, `grant_any`.
  - Reusable by other shared-resource controllers.
- **Top level:** FSM, dwell counter, data mux/register.

## Test plan
Simulation uses DWELL=4, N_REQ=4.
- **Reset/first grant:**
  - Stimulus: reset, then `req`=0001 with data0=0x12345678.
  - Response: `ack`=0001 one cycle after the edge; `disp_data`=0x12345678; `disp_valid`=1; `owner`=0.
- **Full contention:**
  - Stimulus: `req`=1111 held.
  - Response: `owner` sequence 0,1,2,3,0, each for exactly 4 cycles; `done`/`ack` pulses coincide at every boundary.
- **Rotation skip:**
  - Stimulus: after owner 1 finishes, `req`=0001 only.
  - Response: requester 0 granted; requesters 2 and 3 skipped; no gap cycle.
- **Idle hold:**
  - Stimulus: single grant of 0xDEADBEEF, then `req`=0.
  - Response: state IDLE; `disp_data` stays 0xDEADBEEF; `done` pulses once.
- **Withdrawal and data sampling:**
  - Stimulus: `req[2]` raised during SHOW of owner 0, then dropped before expiry; `req_data` changed after grant.
  - Response: no `ack[2]`; displayed value unchanged.
- **Reset mid-SHOW:**
  - Stimulus: `resetn` low at `dwell_cnt`=2.
  - Response: immediate `disp_data`=0, `disp_valid`=0; no `done`; next grant goes to lowest requesting index.
